// File: rtl/fft4_pkg.sv
// ============================================================================
// Module   : fft4_pkg
// Purpose  : Shared constants and types for the 4-point FFT butterfly datapath.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fft4_pkg;

   localparam int FFT4_DW   = 16;
   localparam int FRAME_LEN = 6;

   typedef enum logic [1:0] {
      SEL_BUF = 2'd0,
      SEL_IN  = 2'd1,
      SEL_MEM = 2'd2,
      SEL_ILL = 2'd3
   } sel_e;

   typedef struct packed {
      logic signed [FFT4_DW+1:0] re;
      logic signed [FFT4_DW+1:0] im;
   } cplx_t;

   // Natural-order bin of a stage-2 result: pair p yields bins p and p+2.
   function automatic logic [1:0] out_idx(input logic p, input logic second);
      return {second, p};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fft4_bfly_path_if.sv
// ============================================================================
// Module   : fft4_bfly_path_if
// Purpose  : Controller-to-datapath stream and the registered result pair.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fft4_bfly_path_if #(
   parameter int DW = 16
);
   logic [1:0]           sel_sig;
   logic [2:0]           cnt_in;
   logic signed [DW-1:0] din_re;
   logic signed [DW-1:0] din_im;
   logic signed [DW+1:0] dout0_re;
   logic signed [DW+1:0] dout0_im;
   logic signed [DW+1:0] dout1_re;
   logic signed [DW+1:0] dout1_im;
   logic [1:0]           dout_idx0;
   logic [1:0]           dout_idx1;
   logic                 dout_valid;

   modport master (
      output sel_sig, cnt_in, din_re, din_im,
      input  dout0_re, dout0_im, dout1_re, dout1_im,
      input  dout_idx0, dout_idx1, dout_valid
   );

   modport slave (
      input  sel_sig, cnt_in, din_re, din_im,
      output dout0_re, dout0_im, dout1_re, dout1_im,
      output dout_idx0, dout_idx1, dout_valid
   );
endinterface

`default_nettype wire

// File: rtl/fft4_bfly.sv
// ============================================================================
// Module   : fft4_bfly
// Purpose  : Combinational radix-2 butterfly with optional -j twiddle on the
//            difference; FFT4_SCALE_EN halves (floor) every output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft4_bfly #(
   parameter int W = 18
) (
   input  logic signed [W-1:0] a_re,
   input  logic signed [W-1:0] a_im,
   input  logic signed [W-1:0] b_re,
   input  logic signed [W-1:0] b_im,
   input  logic                neg_j,
   output logic signed [W-1:0] sum_re,
   output logic signed [W-1:0] sum_im,
   output logic signed [W-1:0] dif_re,
   output logic signed [W-1:0] dif_im
);

   logic signed [W-1:0] d_re;
   logic signed [W-1:0] d_im;

`ifdef FFT4_SCALE_EN
   logic signed [W:0] s_re_x;
   logic signed [W:0] s_im_x;
   logic signed [W:0] d_re_x;
   logic signed [W:0] d_im_x;

   // One guard bit so the floor shift never loses the carry.
   assign s_re_x = {a_re[W-1], a_re} + {b_re[W-1], b_re};
   assign s_im_x = {a_im[W-1], a_im} + {b_im[W-1], b_im};
   assign d_re_x = {a_re[W-1], a_re} - {b_re[W-1], b_re};
   assign d_im_x = {a_im[W-1], a_im} - {b_im[W-1], b_im};

   assign sum_re = s_re_x[W:1];
   assign sum_im = s_im_x[W:1];
   assign d_re   = d_re_x[W:1];
   assign d_im   = d_im_x[W:1];
`else
   assign sum_re = a_re + b_re;
   assign sum_im = a_im + b_im;
   assign d_re   = a_re - b_re;
   assign d_im   = a_im - b_im;
`endif

   // Multiplying by -j maps (re, im) to (im, -re).
   assign dif_re = neg_j ? d_im : d_re;
   assign dif_im = neg_j ? -d_re : d_im;

endmodule

`default_nettype wire

// File: rtl/fft4_bfly_path.sv
// ============================================================================
// Module   : fft4_bfly_path
// Purpose  : In-place 4-point DIF FFT datapath driven by an external frame
//            controller; optional 1/4 scaling via FFT4_SCALE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft4_bfly_path
   import fft4_pkg::*;
#(
   parameter int DW = FFT4_DW
) (
   input  logic            clk,
   input  logic            rst_n,
   fft4_bfly_path_if.slave bus
);

   localparam int W = DW + 2;

   logic signed [W-1:0] mem_re [4];
   logic signed [W-1:0] mem_im [4];

   sel_e                sel;
   logic                k;
   logic signed [W-1:0] din_re_x;
   logic signed [W-1:0] din_im_x;
   logic signed [W-1:0] a_re;
   logic signed [W-1:0] a_im;
   logic signed [W-1:0] b_re;
   logic signed [W-1:0] b_im;
   logic                neg_j;
   logic signed [W-1:0] sum_re;
   logic signed [W-1:0] sum_im;
   logic signed [W-1:0] dif_re;
   logic signed [W-1:0] dif_im;

   assign sel      = sel_e'(bus.sel_sig);
   assign k        = bus.cnt_in[0];
   assign din_re_x = {{2{bus.din_re[DW-1]}}, bus.din_re};
   assign din_im_x = {{2{bus.din_im[DW-1]}}, bus.din_im};

   // Stage 1 pairs buffered x[k] with live x[k+2]; stage 2 pairs mem[2p]/mem[2p+1].
   always_comb begin
      a_re  = '0;
      a_im  = '0;
      b_re  = '0;
      b_im  = '0;
      neg_j = 1'b0;
      case (sel)
         SEL_IN: begin
            a_re  = mem_re[{1'b0, k}];
            a_im  = mem_im[{1'b0, k}];
            b_re  = din_re_x;
            b_im  = din_im_x;
            neg_j = k;
         end
         SEL_MEM: begin
            a_re = mem_re[{k, 1'b0}];
            a_im = mem_im[{k, 1'b0}];
            b_re = mem_re[{k, 1'b1}];
            b_im = mem_im[{k, 1'b1}];
         end
         default: ;
      endcase
   end

   fft4_bfly #(
      .W (W)
   ) u_bfly (
      .a_re   (a_re),
      .a_im   (a_im),
      .b_re   (b_re),
      .b_im   (b_im),
      .neg_j  (neg_j),
      .sum_re (sum_re),
      .sum_im (sum_im),
      .dif_re (dif_re),
      .dif_im (dif_im)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            mem_re[i] <= '0;
            mem_im[i] <= '0;
         end
         bus.dout0_re   <= '0;
         bus.dout0_im   <= '0;
         bus.dout1_re   <= '0;
         bus.dout1_im   <= '0;
         bus.dout_idx0  <= '0;
         bus.dout_idx1  <= '0;
         bus.dout_valid <= 1'b0;
      end else begin
         bus.dout_valid <= 1'b0;
         case (sel)
            SEL_BUF: begin
               mem_re[{1'b0, k}] <= din_re_x;
               mem_im[{1'b0, k}] <= din_im_x;
            end
            SEL_IN: begin
               mem_re[{1'b0, k}] <= sum_re;
               mem_im[{1'b0, k}] <= sum_im;
               mem_re[{1'b1, k}] <= dif_re;
               mem_im[{1'b1, k}] <= dif_im;
            end
            SEL_MEM: begin
               mem_re[{k, 1'b0}] <= sum_re;
               mem_im[{k, 1'b0}] <= sum_im;
               mem_re[{k, 1'b1}] <= dif_re;
               mem_im[{k, 1'b1}] <= dif_im;
               bus.dout0_re      <= sum_re;
               bus.dout0_im      <= sum_im;
               bus.dout1_re      <= dif_re;
               bus.dout1_im      <= dif_im;
               bus.dout_idx0     <= out_idx(k, 1'b0);
               bus.dout_idx1     <= out_idx(k, 1'b1);
               bus.dout_valid    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fft4_bfly_path.sv
// ============================================================================
// Module   : tb_fft4_bfly_path
// Purpose  : Scoreboard bench: frames driven as the controller would, results
//            checked against a direct 4-point DFT (staged floor model if scaled).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft4_bfly_path;
   import fft4_pkg::*;

   localparam int DW = FFT4_DW;
   localparam int W  = DW + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft4_bfly_path_if #(.DW(DW)) bus ();

   fft4_bfly_path #(.DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      cplx_t      d0;
      cplx_t      d1;
      logic [1:0] i0;
      logic [1:0] i1;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endfunction

   // Reference: X[k] = sum_n x[n] * (-j)^(n*k).
   function automatic void ref_fft(input int xr[4], input int xi[4],
                                   output int yr[4], output int yi[4]);
`ifdef FFT4_SCALE_EN
      int s0r, s0i, s1r, s1i, d0r, d0i, tr, ti, d1r, d1i;
      s0r = (xr[0] + xr[2]) >>> 1;  s0i = (xi[0] + xi[2]) >>> 1;
      d0r = (xr[0] - xr[2]) >>> 1;  d0i = (xi[0] - xi[2]) >>> 1;
      s1r = (xr[1] + xr[3]) >>> 1;  s1i = (xi[1] + xi[3]) >>> 1;
      tr  = (xr[1] - xr[3]) >>> 1;  ti  = (xi[1] - xi[3]) >>> 1;
      d1r = ti;                     d1i = -tr;
      yr[0] = (s0r + s1r) >>> 1;    yi[0] = (s0i + s1i) >>> 1;
      yr[2] = (s0r - s1r) >>> 1;    yi[2] = (s0i - s1i) >>> 1;
      yr[1] = (d0r + d1r) >>> 1;    yi[1] = (d0i + d1i) >>> 1;
      yr[3] = (d0r - d1r) >>> 1;    yi[3] = (d0i - d1i) >>> 1;
`else
      for (int kk = 0; kk < 4; kk++) begin
         yr[kk] = 0;
         yi[kk] = 0;
         for (int n = 0; n < 4; n++) begin
            case ((n * kk) % 4)
               0: begin yr[kk] += xr[n]; yi[kk] += xi[n]; end
               1: begin yr[kk] += xi[n]; yi[kk] -= xr[n]; end
               2: begin yr[kk] -= xr[n]; yi[kk] -= xi[n]; end
               default: begin yr[kk] -= xi[n]; yi[kk] += xr[n]; end
            endcase
         end
      end
`endif
   endfunction

   task automatic push_pair(input int yr[4], input int yi[4], input int p);
      exp_t e;
      e.d0.re = W'(yr[p]);
      e.d0.im = W'(yi[p]);
      e.d1.re = W'(yr[p + 2]);
      e.d1.im = W'(yi[p + 2]);
      e.i0    = 2'(p);
      e.i1    = 2'(p + 2);
      q.push_back(e);
   endtask

   task automatic drive(input logic [1:0] s, input int c, input int r, input int i);
      @(negedge clk);
      bus.sel_sig = s;
      bus.cnt_in  = 3'(c);
      bus.din_re  = DW'(r);
      bus.din_im  = DW'(i);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_valid"}, int'(bus.dout_valid), 0);
      chk({tag, "_d0re"}, int'(bus.dout0_re), 0);
      chk({tag, "_d0im"}, int'(bus.dout0_im), 0);
      chk({tag, "_d1re"}, int'(bus.dout1_re), 0);
      chk({tag, "_d1im"}, int'(bus.dout1_im), 0);
      chk({tag, "_idx1"}, int'(bus.dout_idx1), 0);
   endtask

   // abort_at >= 0 pulses reset during that phase; bad4 forces sel=3 on phase 4.
   task automatic run_frame(input int xr[4], input int xi[4],
                            input int abort_at, input bit bad4);
      int yr[4], yi[4];
      ref_fft(xr, xi, yr, yi);
      for (int ph = 0; ph < FRAME_LEN; ph++) begin
         case (ph)
            0, 1: drive(SEL_BUF, ph, xr[ph], xi[ph]);
            2, 3: drive(SEL_IN, ph, xr[ph], xi[ph]);
            4: begin
               if (bad4) begin
                  drive(SEL_ILL, ph, int'($urandom), int'($urandom));
               end else begin
                  push_pair(yr, yi, 0);
                  drive(SEL_MEM, ph, int'($urandom), int'($urandom));
               end
            end
            default: begin
               push_pair(yr, yi, 1);
               drive(SEL_MEM, ph, int'($urandom), int'($urandom));
            end
         endcase
         if (ph == abort_at) begin
            #2 rst_n = 1'b0;
            #1 check_cleared("async_rst");
            @(negedge clk);
            bus.sel_sig = SEL_ILL;
            rst_n       = 1'b1;
            return;
         end
         if (ph == 4 && bad4) begin
            @(posedge clk);
            #1 chk("illegal_sel_valid", int'(bus.dout_valid), 0);
         end
      end
   endtask

   // Monitor: every presented pair is matched against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.dout_valid) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: got valid=1 expected no pending result");
            end else begin
               e = q.pop_front();
               chk("dout0_re", int'(bus.dout0_re), int'(e.d0.re));
               chk("dout0_im", int'(bus.dout0_im), int'(e.d0.im));
               chk("dout1_re", int'(bus.dout1_re), int'(e.d1.re));
               chk("dout1_im", int'(bus.dout1_im), int'(e.d1.im));
               chk("dout_idx0", int'(bus.dout_idx0), int'(e.i0));
               chk("dout_idx1", int'(bus.dout_idx1), int'(e.i1));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: got no completion expected finish before 400000");
      $fatal(1, "timeout");
   end

   initial begin
      int xr[4], xi[4];
      bus.sel_sig = SEL_ILL;
      bus.cnt_in  = '0;
      bus.din_re  = '0;
      bus.din_im  = '0;
      repeat (2) @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1;

      run_frame('{1, 2, 3, 4}, '{0, 0, 0, 0}, -1, 1'b0);
      run_frame('{1, 0, 0, 0}, '{0, 0, 0, 0}, -1, 1'b0);
      run_frame('{5, 5, 5, 5}, '{0, 0, 0, 0}, -1, 1'b0);
      run_frame('{-32768, -32768, -32768, -32768},
                '{-32768, -32768, -32768, -32768}, -1, 1'b0);
      run_frame('{1, 2, 3, 4}, '{0, 0, 0, 0}, 3, 1'b0);
      run_frame('{1, 2, 3, 4}, '{0, 0, 0, 0}, -1, 1'b0);

      for (int n = 0; n < 4; n++) begin
         xr[n] = int'($signed(DW'($urandom)));
         xi[n] = int'($signed(DW'($urandom)));
      end
      run_frame(xr, xi, -1, 1'b1);

      for (int f = 0; f < 100; f++) begin
         for (int n = 0; n < 4; n++) begin
            xr[n] = int'($signed(DW'($urandom)));
            xi[n] = int'($signed(DW'($urandom)));
         end
         run_frame(xr, xi, -1, 1'b0);
      end

      drive(SEL_ILL, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
